// File: rtl/upg_pkg.sv
// Shared definitions for the UART programming (UPG) write path.
//   state_t    : frame-parser states
//   SYNC_BYTE  : frame start marker
//   TGT_*      : bit positions inside the TGT byte
package upg_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_TGT  = 3'd3,
    S_DATA = 3'd4,
    S_CSUM = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int TGT_DMEM = 0;  // 1 = data memory, 0 = instruction memory
  localparam int TGT_LAST = 1;  // frame is the final one of the programming session

endpackage

// File: rtl/upg_timeout_timer.sv
// Inter-byte timeout for the UPG frame parser.
//   clk, rst_n : clock, async active-low reset
//   en         : parser is inside a frame (timer runs)
//   load       : a byte was accepted this cycle (restart the window)
//   expired    : TIMEOUT_CYC consecutive idle cycles have elapsed while enabled
module upg_timeout_timer #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Preloaded with TIMEOUT_CYC-1 so that the expiring edge is the
  // TIMEOUT_CYC-th idle edge after the last accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (load || !en)     cnt <= CNT_W'(TIMEOUT_CYC - 1);
    else if (cnt != '0)       cnt <= cnt - CNT_W'(1);
  end

  // A byte arriving on the expiring cycle wins.
  assign expired = en && !load && (cnt == '0);

endmodule

// File: rtl/upg_frame_writer.sv
// UPG write side: parses framed UART bytes into 32-bit memory word writes.
//   upg_clk_i, upg_rstn_i : clock, async active-low reset
//   rx_valid_i, rx_data_i : received byte strobe / value (no back-pressure)
//   upg_wen_o             : one-cycle write strobe
//   upg_adr_o             : {dmem select, word index}, held between strobes
//   upg_dat_o             : write data, held between strobes
//   upg_done_o            : sticky, final frame accepted
//   upg_err_o             : oversize / bad checksum / timeout, cleared by next SYNC
module upg_frame_writer
  import upg_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              upg_clk_i,
  input  logic              upg_rstn_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              upg_wen_o,
  output logic [ADDR_W:0]   upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o
);

  localparam logic [16:0] LEN_MAX = 17'(2 ** ADDR_W);

  state_t            state, state_nxt;
  logic [7:0]        len_lo;
  logic              len_zero;
  logic [ADDR_W-1:0] len_m1;     // index of the final word of the frame
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [23:0]       asm_q;      // lanes 0..2; lane 3 comes straight from rx_data_i
  logic [7:0]        csum;
  logic              tgt_dmem, tgt_last;
  logic              timer_en, tmo;
  logic              wen_nxt, err_set, err_clr, done_set;
  logic [16:0]       len_full;

  assign len_full = {1'b0, rx_data_i, len_lo};
  assign timer_en = (state != S_IDLE) && (state != S_DONE);

  upg_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (upg_clk_i),
    .rst_n   (upg_rstn_i),
    .en      (timer_en),
    .load    (rx_valid_i),
    .expired (tmo)
  );

  always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
    if (!upg_rstn_i) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wen_nxt   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    done_set  = 1'b0;
    if (tmo) begin
      state_nxt = S_IDLE;
      err_set   = 1'b1;
    end else if (rx_valid_i) begin
      case (state)
        S_IDLE: if (rx_data_i == SYNC_BYTE) begin
          state_nxt = S_LEN0;
          err_clr   = 1'b1;
        end
        S_LEN0: state_nxt = S_LEN1;
        S_LEN1: if (len_full > LEN_MAX) begin
          state_nxt = S_IDLE;
          err_set   = 1'b1;
        end else begin
          state_nxt = S_TGT;
        end
        S_TGT:  state_nxt = len_zero ? S_CSUM : S_DATA;
        S_DATA: if (lane == 2'd3) begin
          wen_nxt = 1'b1;
          if (word_idx == len_m1) state_nxt = S_CSUM;
        end
        S_CSUM: if (rx_data_i == csum) begin
          state_nxt = tgt_last ? S_DONE : S_IDLE;
          done_set  = tgt_last;
        end else begin
          state_nxt = S_IDLE;
          err_set   = 1'b1;
        end
        default: ;  // S_DONE: ignore everything until reset
      endcase
    end
  end

  always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
    if (!upg_rstn_i) begin
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      upg_err_o  <= 1'b0;
      len_lo     <= '0;
      len_zero   <= 1'b0;
      len_m1     <= '0;
      word_idx   <= '0;
      lane       <= '0;
      asm_q      <= '0;
      csum       <= '0;
      tgt_dmem   <= 1'b0;
      tgt_last   <= 1'b0;
    end else begin
      upg_wen_o <= wen_nxt;
      if (wen_nxt) begin
        upg_adr_o <= {tgt_dmem, word_idx};
        upg_dat_o <= {rx_data_i, asm_q};
      end
      if (err_set)      upg_err_o <= 1'b1;
      else if (err_clr) upg_err_o <= 1'b0;
      if (done_set)     upg_done_o <= 1'b1;

      if (rx_valid_i && !tmo) begin
        case (state)
          S_IDLE: if (rx_data_i == SYNC_BYTE) begin
            csum     <= '0;
            lane     <= '0;
            word_idx <= '0;
          end
          S_LEN0: len_lo <= rx_data_i;
          S_LEN1: begin
            len_zero <= (len_full == 17'd0);
            len_m1   <= len_full[ADDR_W-1:0] - ADDR_W'(1);
          end
          S_TGT: begin
            tgt_dmem <= rx_data_i[TGT_DMEM];
            tgt_last <= rx_data_i[TGT_LAST];
            word_idx <= '0;
            lane     <= '0;
          end
          S_DATA: begin
            csum <= csum ^ rx_data_i;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: asm_q[7:0]   <= rx_data_i;
              2'd1: asm_q[15:8]  <= rx_data_i;
              2'd2: asm_q[23:16] <= rx_data_i;
              default: word_idx  <= word_idx + ADDR_W'(1);
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_upg_frame_writer.sv
module tb_upg_frame_writer;

  localparam int ADDR_W = 14;
  localparam int TMO    = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef logic [ADDR_W+32:0] wr_t;  // {adr, dat}

  logic              clk = 1'b0;
  logic              rstn;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              wen;
  logic [ADDR_W:0]   adr;
  logic [31:0]       dat;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] fr_q[$];
  logic       m_err, m_done;

  upg_frame_writer #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .upg_clk_i  (clk),
    .upg_rstn_i (rstn),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .upg_wen_o  (wen),
    .upg_adr_o  (adr),
    .upg_dat_o  (dat),
    .upg_done_o (done),
    .upg_err_o  (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wen === 1'b1) got_q.push_back({adr, dat});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Reference: interpret a complete frame by its meaning (length, target, words, XOR).
  task automatic model_frame();
    int unsigned len;
    logic [7:0]  tgt, cs;
    if (m_done) return;
    m_err = 1'b0;
    len = {fr_q[2], fr_q[1]};
    if (len > 2 ** ADDR_W) begin
      m_err = 1'b1;
      return;
    end
    tgt = fr_q[3];
    cs  = 8'h00;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back({tgt[0], ADDR_W'(i),
                       fr_q[4+4*i+3], fr_q[4+4*i+2], fr_q[4+4*i+1], fr_q[4+4*i]});
      for (int k = 0; k < 4; k++) cs ^= fr_q[4+4*i+k];
    end
    if (fr_q[4+4*len] == cs) begin
      if (tgt[1]) m_done = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Called at a negedge; leaves at a negedge.
  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_wr"}, 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_err"},  64'(err),  64'(m_err));
    chk({tag, "_done"}, 64'(done), 64'(m_done));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input string tag, input int maxgap);
    got_q.delete();
    exp_q.delete();
    model_frame();
    foreach (fr_q[i]) send(fr_q[i], $urandom_range(0, maxgap));
    repeat (3) @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    int unsigned len;
    logic [7:0]  cs, b, tgt;

    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    m_err = 1'b0; m_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_adr", 64'(adr), 64'd0);
    chk("rst_dat", 64'(dat), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // imem frame, bytes back to back
    fr_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_frame("imem", 0);
    chk("imem_hold_adr", 64'(adr), 64'h0001);
    chk("imem_hold_dat", 64'(dat), 64'h88776655);

    // last dmem frame with bad checksum
    fr_q = '{8'hA5, 8'h01, 8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    run_frame("badcs", 1);
    chk("badcs_adr", 64'(adr), 64'h4000);

    // SYNC clears err; then stall after two data bytes
    send(SYNC, 0);
    chk("sync_clr_err", 64'(err), 64'd0);
    foreach (fr_q[i]) if (i >= 1 && i <= 5) send(fr_q[i], 0);
    got_q.delete();
    repeat (TMO + 5) @(negedge clk);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_nwr", 64'(got_q.size()), 64'd0);
    m_err = 1'b1;

    // random non-final frames with random gaps and occasional bad checksum
    for (int f = 0; f < 20; f++) begin
      fr_q.delete();
      len = $urandom_range(0, 5);
      tgt = 8'($urandom) & 8'hFD;
      fr_q.push_back(SYNC);
      fr_q.push_back(len[7:0]);
      fr_q.push_back(8'h00);
      fr_q.push_back(tgt);
      cs = 8'h00;
      for (int i = 0; i < int'(4 * len); i++) begin
        b = 8'($urandom);
        cs ^= b;
        fr_q.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
      fr_q.push_back(cs);
      run_frame("rand", 3);
    end

    // oversize length
    fr_q = '{8'hA5, 8'h01, 8'h41};
    run_frame("oversize", 0);

    // async reset in the middle of a word
    got_q.delete();
    fr_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h11, 8'h22};
    foreach (fr_q[i]) send(fr_q[i], 0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_wen", 64'(wen), 64'd0);
    chk("arst_adr", 64'(adr), 64'd0);
    chk("arst_dat", 64'(dat), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("arst_nwr", 64'(got_q.size()), 64'd0);
    m_err = 1'b0; m_done = 1'b0;
    fr_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    run_frame("post_rst", 0);
    chk("post_rst_adr", 64'(adr), 64'h0000);
    chk("post_rst_dat", 64'(dat), 64'hDDCCBBAA);

    // final dmem frame: done one cycle after the checksum byte
    fr_q = '{8'hA5, 8'h01, 8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    got_q.delete();
    exp_q.delete();
    model_frame();
    for (int i = 0; i < 8; i++) send(fr_q[i], 0);
    chk("last_done_pre", 64'(done), 64'd0);
    send(fr_q[8], 0);
    chk("last_done", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
    compare_all("last");
    chk("last_adr", 64'(adr), 64'h4000);
    chk("last_dat", 64'(dat), 64'hEFBEADDE);

    // everything after done is ignored
    fr_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_frame("after_done", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
